// File: rtl/komut_kodlayici.sv
// komut_kodlayici: packs instruction fields into 32-bit komut words
// behind a small FIFO; optional counters with KOMUT_SAYAC_EN.
module komut_kodlayici #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 tip,
  input  logic [3:0]                 aluop,
  input  logic [4:0]                 rs1,
  input  logic [4:0]                 rs2,
  input  logic [4:0]                 rd,
  input  logic [31:0]                imm,
  input  logic                       giris_gecerli,
  output logic                       giris_hazir,
  output logic [31:0]                komut,
  output logic                       cikis_gecerli,
  input  logic                       cikis_hazir,
  output logic                       hata,
`ifdef KOMUT_SAYAC_EN
  output logic [15:0]                kabul_sayisi,
  output logic [15:0]                red_sayisi,
`endif
  output logic [$clog2(DEPTH):0]     doluluk
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic [31:0]   kelime;
  logic          red;
  logic          kabul;
  logic          push;
  logic          pop;

  assign giris_hazir   = (cnt != CW'(DEPTH));
  assign cikis_gecerli = (cnt != '0);
  assign komut         = cikis_gecerli ? mem[rd_ptr] : 32'd0;
  assign doluluk       = cnt;

  assign kabul = giris_gecerli && giris_hazir;
  assign push  = kabul && !red;
  assign pop   = cikis_gecerli && cikis_hazir;

  // Field packing and representability check per instruction type
  always_comb begin
    kelime = 32'd0;
    red    = 1'b0;
    unique case (tip)
      2'b00: begin
        kelime[6:0]   = 7'b0000001;
        kelime[11:7]  = rd;
        kelime[14:12] = aluop[2:0];
        kelime[19:15] = rs1;
        kelime[24:20] = rs2;
        kelime[30]    = aluop[3];
      end
      2'b01: begin
        kelime[6:0]   = 7'b0000011;
        kelime[11:7]  = rd;
        kelime[14:12] = aluop[2:0];
        kelime[19:15] = rs1;
        kelime[31:20] = imm[11:0];
        red = aluop[3] || (imm[31:12] != '0);
      end
      2'b10: begin
        kelime[6:0]   = 7'b0000111;
        kelime[11:7]  = rd;
        kelime[31:12] = imm[19:0];
        red = (imm[31:20] != '0);
      end
      default: begin
        kelime[6:0]   = 7'b0001111;
        kelime[11:7]  = imm[5:1];
        kelime[14:12] = aluop[2:0];
        kelime[19:15] = rs1;
        kelime[24:20] = rs2;
        kelime[31:25] = imm[12:6];
        red = aluop[3] || imm[0] || (imm[31:13] != '0);
      end
    endcase
  end

  // Storage array; contents need no reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= kelime;
  end

  // Pointers, occupancy and the reject pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      hata   <= 1'b0;
    end else begin
      hata <= kabul && red;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef KOMUT_SAYAC_EN
  // Pushed and rejected word counters, wrapping at 16 bits
  always_ff @(posedge clk) begin
    if (reset) begin
      kabul_sayisi <= '0;
      red_sayisi   <= '0;
    end else begin
      if (push)         kabul_sayisi <= kabul_sayisi + 1'b1;
      if (kabul && red) red_sayisi   <= red_sayisi + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_komut_kodlayici.sv
// Directed bench for komut_kodlayici: packing, rejects,
// backpressure and mid-stream reset.
module tb_komut_kodlayici;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  tip;
  logic [3:0]  aluop;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm;
  logic        giris_gecerli;
  logic        giris_hazir;
  logic [31:0] komut;
  logic        cikis_gecerli;
  logic        cikis_hazir;
  logic        hata;
  logic [2:0]  doluluk;
`ifdef KOMUT_SAYAC_EN
  logic [15:0] kabul_sayisi;
  logic [15:0] red_sayisi;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  komut_kodlayici #(.DEPTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .tip           (tip),
    .aluop         (aluop),
    .rs1           (rs1),
    .rs2           (rs2),
    .rd            (rd),
    .imm           (imm),
    .giris_gecerli (giris_gecerli),
    .giris_hazir   (giris_hazir),
    .komut         (komut),
    .cikis_gecerli (cikis_gecerli),
    .cikis_hazir   (cikis_hazir),
    .hata          (hata),
`ifdef KOMUT_SAYAC_EN
    .kabul_sayisi  (kabul_sayisi),
    .red_sayisi    (red_sayisi),
`endif
    .doluluk       (doluluk)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] t, input logic [3:0] a,
                       input logic [4:0] s1, input logic [4:0] s2,
                       input logic [4:0] d, input logic [31:0] i);
    tip = t; aluop = a; rs1 = s1; rs2 = s2; rd = d; imm = i;
    giris_gecerli = 1'b1;
  endtask

  task automatic put(input string tag,
                     input logic [1:0] t, input logic [3:0] a,
                     input logic [4:0] s1, input logic [4:0] s2,
                     input logic [4:0] d, input logic [31:0] i,
                     input logic [31:0] exp);
    drive(t, a, s1, s2, d, i);
    tick();
    giris_gecerli = 1'b0;
    chk({tag, "_komut"}, komut, exp);
    chk({tag, "_gecerli"}, 32'(cikis_gecerli), 32'd1);
    chk({tag, "_hata"}, 32'(hata), 32'd0);
    cikis_hazir = 1'b1;
    tick();
    cikis_hazir = 1'b0;
    chk({tag, "_bos"}, 32'(doluluk), 32'd0);
  endtask

  function automatic logic [31:0] rw(input int k);
    return 32'h1 | (32'(k) << 7);
  endfunction

  initial begin
    reset = 1'b1;
    giris_gecerli = 1'b0;
    cikis_hazir = 1'b0;
    tip = '0; aluop = '0; rs1 = '0; rs2 = '0; rd = '0; imm = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_hazir", 32'(giris_hazir), 32'd1);
    chk("rst_gecerli", 32'(cikis_gecerli), 32'd0);
    chk("rst_komut", komut, 32'd0);
    chk("rst_hata", 32'(hata), 32'd0);
    chk("rst_doluluk", 32'(doluluk), 32'd0);

    // back-to-back rejects
    drive(2'b11, 4'b0001, 5'd1, 5'd2, 5'd0, 32'h3);
    tick();
    chk("rejB_hata", 32'(hata), 32'd1);
    chk("rejB_dol", 32'(doluluk), 32'd0);
    drive(2'b01, 4'b0010, 5'd5, 5'd0, 5'd6, 32'h1000);
    tick();
    giris_gecerli = 1'b0;
    chk("rejI_hata", 32'(hata), 32'd1);
    chk("rejI_dol", 32'(doluluk), 32'd0);
    tick();
    chk("rej_hata_low", 32'(hata), 32'd0);
`ifdef KOMUT_SAYAC_EN
    chk("cnt_red2", 32'(red_sayisi), 32'd2);
    chk("cnt_kabul0", 32'(kabul_sayisi), 32'd0);
`endif

    put("R", 2'b00, 4'b1000, 5'd2, 5'd3, 5'd1, 32'h0, 32'h40310081);
    put("I", 2'b01, 4'b0010, 5'd5, 5'd0, 5'd6, 32'h123, 32'h1232A303);
    put("U", 2'b10, 4'b0000, 5'd0, 5'd0, 5'd31, 32'hABCDE, 32'hABCDEF87);
    put("B", 2'b11, 4'b0001, 5'd1, 5'd2, 5'd0, 32'h0FFE, 32'h7E209F8F);

    // fill with backpressure
    cikis_hazir = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      drive(2'b00, 4'b0000, 5'd0, 5'd0, 5'(k), 32'h0);
      tick();
    end
    chk("full_dol", 32'(doluluk), 32'd4);
    chk("full_hazir", 32'(giris_hazir), 32'd0);
    chk("full_head", komut, rw(1));
    drive(2'b00, 4'b0000, 5'd0, 5'd0, 5'd5, 32'h0);
    tick();
    chk("held_dol", 32'(doluluk), 32'd4);
    chk("held_head", komut, rw(1));
    chk("held_gecerli", 32'(cikis_gecerli), 32'd1);

    cikis_hazir = 1'b1;
    tick();
    chk("pop1_dol", 32'(doluluk), 32'd3);
    chk("pop1_head", komut, rw(2));
    chk("pop1_hazir", 32'(giris_hazir), 32'd1);
    tick();
    giris_gecerli = 1'b0;
    chk("pushpop_dol", 32'(doluluk), 32'd3);
    chk("pushpop_head", komut, rw(3));
    tick();
    chk("pop3_dol", 32'(doluluk), 32'd2);
    chk("pop3_head", komut, rw(4));

    // rejected accept with a pop
    drive(2'b10, 4'b0000, 5'd0, 5'd0, 5'd7, 32'h100000);
    tick();
    giris_gecerli = 1'b0;
    cikis_hazir = 1'b0;
    chk("rejpop_dol", 32'(doluluk), 32'd1);
    chk("rejpop_hata", 32'(hata), 32'd1);
    chk("rejpop_head", komut, rw(5));

    drive(2'b00, 4'b0000, 5'd0, 5'd0, 5'd6, 32'h0);
    tick();
    giris_gecerli = 1'b0;
    chk("w6_dol", 32'(doluluk), 32'd2);
    chk("w6_hata", 32'(hata), 32'd0);
`ifdef KOMUT_SAYAC_EN
    chk("cnt_kabul10", 32'(kabul_sayisi), 32'd10);
    chk("cnt_red3", 32'(red_sayisi), 32'd3);
`endif

    // mid-stream reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_dol", 32'(doluluk), 32'd0);
    chk("mrst_gecerli", 32'(cikis_gecerli), 32'd0);
    chk("mrst_komut", komut, 32'd0);
    chk("mrst_hazir", 32'(giris_hazir), 32'd1);
`ifdef KOMUT_SAYAC_EN
    chk("mrst_kabul", 32'(kabul_sayisi), 32'd0);
    chk("mrst_red", 32'(red_sayisi), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
